// File: rtl/priority_encoder_32to5.sv
// Sequential 32-to-5 encoder: sticky request capture, registered index on a valid/ready port.
// Define PRIORITY_ENC_ROUND_ROBIN_EN for round-robin selection instead of lowest-index priority.
module priority_encoder_32to5 #(
    parameter int unsigned N     = 32,
    parameter int unsigned IDX_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [N-1:0]     req_in,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_index,
    output logic [N-1:0]     pending,
    output logic             any_pending
);

    typedef enum logic [0:0] {StIdle, StPresent} state_e;

    state_e           state_q, state_d;
    logic [N-1:0]     pending_q, pending_d;
    logic [N-1:0]     clr;
    logic [IDX_W-1:0] out_index_q;
    logic [IDX_W-1:0] sel_base;
    logic [IDX_W-1:0] sel_idx;
    logic             handshake;

    // First set bit of vec at or above base, wrapping modulo N.
    function automatic logic [IDX_W-1:0] select_idx(input logic [N-1:0] vec,
                                                    input logic [IDX_W-1:0] base);
        logic             found;
        logic [IDX_W-1:0] idx;
        logic [IDX_W-1:0] cand;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            cand = base + IDX_W'(k);
            if (!found && vec[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
        return idx;
    endfunction

    assign handshake = out_valid & out_ready;

`ifdef PRIORITY_ENC_ROUND_ROBIN_EN
    logic [IDX_W-1:0] rr_ptr;

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (handshake) begin
            rr_ptr <= out_index_q + IDX_W'(1);
        end
    end

    assign sel_base = rr_ptr;
`else
    assign sel_base = '0;
`endif

    assign sel_idx = select_idx(pending_q, sel_base);

    always_comb begin
        clr = '0;
        if (handshake) begin
            clr[out_index_q] = 1'b1;
        end
    end

    // A line re-requested in its own accept cycle stays pending.
    assign pending_d = (pending_q & ~clr) | ({N{enable}} & req_in);

    always_ff @(posedge clock) begin
        if (reset) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    // FSM: state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (pending_q != '0) state_d = StPresent;
            StPresent: if (out_ready) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // FSM: outputs
    always_comb begin
        out_valid = (state_q == StPresent);
    end

    // Index is loaded only when leaving idle, so it holds through any stall.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_index_q <= '0;
        end else if (state_q == StIdle && pending_q != '0) begin
            out_index_q <= sel_idx;
        end
    end

    assign out_index   = out_index_q;
    assign pending     = pending_q;
    assign any_pending = |pending_q;

endmodule

// File: doc/priority_encoder_32to5.md
Name: priority_encoder_32to5

Overview:
- Sequential 32-to-5 encoder: the inverse of the register-select decode path.
- Collects single-cycle request pulses on 32 lines into a sticky pending vector.
- Selects one pending line and presents its 5-bit index on a valid/ready output port.
- Clears that line once the index is accepted.
- Used for interrupt/exception source encoding and hazard-source reporting in the processor.

Parameters:
- N, 32, number of request lines; only 32 is supported.
- IDX_W, 5, index width; must equal log2(N).

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  when high, req_in bits are captured into pending; when low, req_in is ignored.
- req_in  input  N  request pulses; bit i set for one or more cycles.
- out_ready  input  1  consumer accepts out_index when high with out_valid.
- out_valid  output  1  out_index holds a valid pending line number.
- out_index  output  IDX_W  encoded index of the selected request line.
- pending  output  N  current sticky pending vector (registered).
- any_pending  output  1  OR-reduction of pending (combinational from the register).

Behaviour:
- Clock and reset: single clock `clock`. Reset `reset` is synchronous and active-high.
- Reset values: pending=0, out_valid=0, out_index=0, rr_ptr=0.
- Reset mid-operation (including while out_valid=1 and stalled): all state returns to reset values on the next edge; the in-flight index is dropped.
- Pending update, per edge:
  - pending_next[i] = (pending[i] & ~clr[i]) | (enable & req_in[i])
  - clr[i] = out_valid & out_ready & (out_index == i).
  - Set wins over clear: a bit re-requested in its own accept cycle stays pending.
- Output FSM, 2 states:
  - IDLE (out_valid=0): if pending != 0, go to PRESENT on the next edge. out_index = select(pending), using the registered pending (not pending_next).
  - PRESENT (out_valid=1): out_index and out_valid hold stable while out_ready=0, regardless of new requests.
  - PRESENT with out_ready=1: handshake completes; go to IDLE. out_valid=0 for exactly one cycle.
  - Sustained throughput is one index per 2 cycles.
- Latency: req_in[i] sampled at edge t → pending[i]=1 after edge t → out_valid=1 after edge t+1, when the FSM is IDLE and i wins selection.
- select() in fixed-priority mode: lowest set index of pending.
- out_index is registered; there is no combinational path from req_in or out_ready to out_index/out_valid.
- pending = 0 in IDLE: remains IDLE, out_index holds its last value (don't-care for consumers).
- All 32 bits pending: selection is still one index per handshake; no overflow condition exists, because requests to an already-pending line merge.
- enable low: pending still drains normally; only capture is suppressed.

Optional Feature:
- Macro: PRIORITY_ENC_ROUND_ROBIN_EN.
- Defined:
  - Adds an IDX_W-bit rr_ptr register, reset to 0, updated on each handshake to (out_index+1) mod 32.
  - select() returns the first set bit of pending at or above rr_ptr, wrapping from 31 to 0.
- Not defined: rr_ptr is absent, and select() is fixed lowest-index priority.
- Port list and timing are identical in both builds.

Test Plan:
1. Single request:
   - Stimulus: reset, then enable=1, req_in=0x0000_0001 for one cycle at edge t, out_ready=1.
   - Response: pending=0x1 after t; out_valid=1 with out_index=0 after t+1; pending=0 and out_valid=0 after t+2.
2. Fixed priority:
   - Stimulus: req_in=0x8000_0010 pulse, out_ready=1.
   - Response: indices 4 then 31, separated by one out_valid=0 cycle; pending ends 0.
3. Backpressure:
   - Stimulus: index 4 presented; hold out_ready=0 for 5 cycles; pulse req_in bit 0 during the stall.
   - Response: out_index stays 4 and out_valid stays 1 throughout. After out_ready=1, the next index is 0.
4. Set-over-clear:
   - Stimulus: req_in bit 7 asserted in the same cycle index 7 handshakes.
   - Response: pending[7] remains 1, and index 7 is presented again after the idle bubble.
5. Enable and reset:
   - Stimulus: enable=0 with req_in=0xFFFF_FFFF.
   - Response: pending stays 0.
   - Stimulus: then reset asserted while out_valid=1.
   - Response: out_valid=0, pending=0 and out_index=0 after the edge.
6. Round robin (macro defined):
   - Stimulus: grant index 4, then pending bits {2,7}.
   - Response: order is 7, 2; rr_ptr reads 8 then 3.
   - Without the macro, the same stimulus gives order 2, 7.
